// File: rtl/dz_uart_tx.sv
// One DZ11 line transmitter: a holding register fed by the TDR scanner in front of a
// format-latching async serializer. dbg_state encodes IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
module dz_uart_tx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic [1:0] txLEN,
    input  logic       txPENA,
    input  logic       txPODD,
    input  logic       txSTOP,
    input  logic       txBRK,
    input  logic       txLOAD,
    input  logic [7:0] txDATA,
    output logic       txEMPTY,
    output logic       txACTIVE,
    output logic       txd,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [5:0] TICK_LAST = 6'(OVERSAMPLE - 1);

    state_t     state_q, state_d;
    logic [5:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] sh_data_q, sh_data_d;
    logic [1:0] sh_len_q, sh_len_d;
    logic       sh_pena_q, sh_pena_d;
    logic       sh_podd_q, sh_podd_d;
    logic       sh_stop_q, sh_stop_d;

    logic       bit_end;
    logic       frame_end;
    logic       transfer;
    logic       line_bit;
    logic [7:0] len_mask;

    // Handshake: txLOAD is a one-clk pulse that is always accepted (it overwrites a full
    // holding register); txEMPTY tells the scanner the holding register is free.
    always_comb begin
        bit_end   = clken && (tick_q == TICK_LAST);
        len_mask  = 8'hFF >> (2'd3 - sh_len_q);
        frame_end = 1'b0;
        line_bit  = 1'b1;
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;

        if (clken) begin
            tick_d = bit_end ? 6'd0 : tick_q + 6'd1;
        end

        case (state_q)
            S_IDLE: begin
                tick_d = 6'd0;
                bit_d  = 3'd0;
            end
            S_START: begin
                line_bit = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                line_bit = sh_data_q[bit_q];
                if (bit_end) begin
                    // Last data bit index is len-1 = 4 + txLEN.
                    if (bit_q == {1'b1, sh_len_q}) begin
                        state_d = sh_pena_q ? S_PARITY : S_STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                line_bit = (^(sh_data_q & len_mask)) ^ sh_podd_q;
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = 3'd0;
                end
            end
            S_STOP: begin
                line_bit = 1'b1;
                if (bit_end) begin
                    if (bit_q[0] == sh_stop_q) begin
                        frame_end = 1'b1;
                        state_d   = S_IDLE;
                        bit_d     = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = 6'd0;
                bit_d   = 3'd0;
            end
        endcase

        // A load on the same clk takes priority; the held char moves on the next chance.
        transfer = hold_full_q && !txLOAD && ((state_q == S_IDLE) || frame_end);
        if (transfer) begin
            state_d = S_START;
            tick_d  = 6'd0;
            bit_d   = 3'd0;
        end

        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (txLOAD) begin
            hold_d      = txDATA;
            hold_full_d = 1'b1;
        end else if (transfer) begin
            hold_full_d = 1'b0;
        end

        sh_data_d = sh_data_q;
        sh_len_d  = sh_len_q;
        sh_pena_d = sh_pena_q;
        sh_podd_d = sh_podd_q;
        sh_stop_d = sh_stop_q;
        if (transfer) begin
            sh_data_d = hold_q;
            sh_len_d  = txLEN;
            sh_pena_d = txPENA;
            sh_podd_d = txPODD;
            sh_stop_d = txSTOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_q      <= 6'd0;
            bit_q       <= 3'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            sh_data_q   <= 8'd0;
            sh_len_q    <= 2'd0;
            sh_pena_q   <= 1'b0;
            sh_podd_q   <= 1'b0;
            sh_stop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_data_q   <= sh_data_d;
            sh_len_q    <= sh_len_d;
            sh_pena_q   <= sh_pena_d;
            sh_podd_q   <= sh_podd_d;
            sh_stop_q   <= sh_stop_d;
        end
    end

    // Reset forces mark immediately; break overrides the serializer without stopping it.
    assign txd       = rst ? 1'b1 : (txBRK ? 1'b0 : line_bit);
    assign txEMPTY   = !hold_full_q;
    assign txACTIVE  = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dz_uart_tx.sv
// Bench for dz_uart_tx: a waveform-level reference model (one expected txd value per clk)
// checked every clk, plus directed frame-length, break, overwrite and slow-clken/reset steps.
module tb_dz_uart_tx;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       clken;
    logic [1:0] txLEN;
    logic       txPENA;
    logic       txPODD;
    logic       txSTOP;
    logic       txBRK;
    logic       txLOAD;
    logic [7:0] txDATA;
    logic       txEMPTY;
    logic       txACTIVE;
    logic       txd;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    dz_uart_tx #(.OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .txLEN     (txLEN),
        .txPENA    (txPENA),
        .txPODD    (txPODD),
        .txSTOP    (txSTOP),
        .txBRK     (txBRK),
        .txLOAD    (txLOAD),
        .txDATA    (txDATA),
        .txEMPTY   (txEMPTY),
        .txACTIVE  (txACTIVE),
        .txd       (txd),
        .dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: expected line level for each upcoming clk of the frames in flight.
    logic [0:0] exp_q[$];
    logic       m_full;
    logic [7:0] m_hold;
    bit         div3;
    bit         chk_model;
    int         cyc;
    int         act_cnt;
    int         empty_low_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Builds a character's waveform from the framing rules, each bit held OS clks.
    function automatic void push_frame(input logic [7:0] d, input logic [1:0] len,
                                       input logic pena, input logic podd, input logic stop);
        logic [0:0] bits[$];
        int n;
        int ones;
        n    = 5 + int'(len);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pena) bits.push_back(1'((ones % 2 == 1) ? 1 : 0) ^ podd);
        bits.push_back(1'b1);
        if (stop) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int r = 0; r < OS; r++) exp_q.push_back(bits[k]);
        end
    endfunction

    task automatic step();
        logic exp_txd;
        logic exp_act;
        @(posedge clk);
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_full = 1'b0;
        end else if (txLOAD) begin
            m_hold = txDATA;
            m_full = 1'b1;
        end else if (m_full && exp_q.size() == 0) begin
            push_frame(m_hold, txLEN, txPENA, txPODD, txSTOP);
            m_full = 1'b0;
        end
        if (exp_q.size() > 0) begin
            exp_txd = exp_q.pop_front();
            exp_act = 1'b1;
        end else begin
            exp_txd = 1'b1;
            exp_act = 1'b0;
        end
        #1;
        if (txACTIVE === 1'b1) act_cnt++;
        if (txEMPTY === 1'b0) empty_low_cnt++;
        if (chk_model) begin
            check("txd", txd, txBRK ? 1'b0 : exp_txd);
            check("txEMPTY", txEMPTY, !m_full);
            check("txACTIVE", txACTIVE, exp_act);
        end
        clken = div3 ? (cyc % 3 == 0) : 1'b1;
    endtask

    task automatic load(input logic [7:0] d);
        txDATA = d;
        txLOAD = 1'b1;
        step();
        txLOAD = 1'b0;
    endtask

    task automatic set_fmt(input logic [1:0] len, input logic pena, input logic podd,
                           input logic stop);
        txLEN  = len;
        txPENA = pena;
        txPODD = podd;
        txSTOP = stop;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while ((exp_q.size() > 0 || m_full) && k < bound) begin
            step();
            k++;
        end
        check("idle_timeout", (k < bound), 1);
        step();
    endtask

    task automatic wait_txd(input logic v, input int bound, output int t);
        int k;
        k = 0;
        while (txd !== v && k < bound) begin
            step();
            k++;
        end
        check("wait_txd_timeout", (txd === v), 1);
        t = cyc;
    endtask

    // Measures the first three cells of an 8N1 0x55 frame under clken every 3 clks.
    task automatic measure_cells(input string tag);
        int t0, t1, t2, t3;
        wait_txd(1'b0, 10, t0);
        wait_txd(1'b1, 60, t1);
        wait_txd(1'b0, 60, t2);
        wait_txd(1'b1, 60, t3);
        check({tag, "_first_cell"}, ((t1 - t0) >= 3 * OS - 2) && ((t1 - t0) <= 3 * OS), 1);
        check({tag, "_cell1"}, t2 - t1, 3 * OS);
        check({tag, "_cell2"}, t3 - t2, 3 * OS);
    endtask

    initial begin
        int bad;
        rst = 1'b1; clken = 1'b1; txLOAD = 1'b0; txDATA = 8'h00; txBRK = 1'b0;
        set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
        div3 = 1'b0; chk_model = 1'b1; cyc = 0; m_full = 1'b0; m_hold = 8'h00;
        act_cnt = 0; empty_low_cnt = 0;

        // Reset state
        repeat (3) step();
        check("reset_dbg_idle", dbg_state, 3'd0);
        rst = 1'b0;
        repeat (4) step();

        // 8N1 0x55
        act_cnt = 0; empty_low_cnt = 0;
        load(8'h55);
        wait_idle(400);
        check("8n1_frame_clks", act_cnt, 10 * OS);
        check("8n1_empty_low_clks", empty_low_cnt, 1);

        // 7E1 0x41
        set_fmt(2'd2, 1'b1, 1'b0, 1'b0);
        act_cnt = 0;
        load(8'h41);
        wait_idle(400);
        check("7e1_frame_clks", act_cnt, 10 * OS);

        // 5O2 0xFF, upper bits ignored
        set_fmt(2'd0, 1'b1, 1'b1, 1'b1);
        act_cnt = 0;
        load(8'hFF);
        wait_idle(400);
        check("5o2_frame_clks", act_cnt, 9 * OS);

        // Back-to-back 8N1: no gap between frames
        set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
        act_cnt = 0;
        load(8'h31);
        bad = 0;
        while (txEMPTY !== 1'b1 && bad < 20) begin
            step();
            bad++;
        end
        check("b2b_empty_timeout", txEMPTY, 1'b1);
        load(8'h32);
        wait_idle(800);
        check("b2b_frame_clks", act_cnt, 20 * OS);

        // Overwrite while full: the second load wins and only it is sent
        act_cnt = 0;
        load(8'hA5);
        load(8'h5A);
        wait_idle(400);
        check("overwrite_frame_clks", act_cnt, 10 * OS);

        // Break mid-frame, with a load during break
        load(8'h55);
        repeat (40) step();
        txBRK = 1'b1;
        repeat (30) step();
        load(8'h0F);
        repeat (30) step();
        txBRK = 1'b0;
        wait_idle(800);

        // Randomized traffic, format changes and break toggles
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                set_fmt(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 299) == 0) txBRK = ~txBRK;
            if ($urandom_range(0, 59) == 0) begin
                txDATA = 8'($urandom_range(0, 255));
                txLOAD = 1'b1;
            end else begin
                txLOAD = 1'b0;
            end
            step();
        end
        txLOAD = 1'b0;
        txBRK  = 1'b0;
        wait_idle(1000);

        // Slow clken, then reset mid-DATA with a char held
        chk_model = 1'b0;
        div3 = 1'b1;
        set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
        load(8'h55);
        measure_cells("div3");
        load(8'h0F);
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("rst_txd_at_once", txd, 1'b1);
        step();
        rst = 1'b0;
        check("rst_txd", txd, 1'b1);
        check("rst_txEMPTY", txEMPTY, 1'b1);
        check("rst_txACTIVE", txACTIVE, 1'b0);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (txd !== 1'b1 || txACTIVE !== 1'b0 || txEMPTY !== 1'b1) bad++;
        end
        check("rst_nothing_sent", bad, 0);
        load(8'h55);
        measure_cells("div3_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
